sae_host_seq: RTL and testbench
===============================

// Module: sae_host_seq
// PURPOSE
//  Host-side sequencer (initiator) for the sae crypto core.
//  - Takes a session command plus a byte stream and issues one sae request per byte.
//  - Returns each sae result, tagged with error flags, on an output stream.
//  - Lets system logic run a keygen, encrypt or decrypt session without per-byte software control.
// PARAMETERS
//  LEN_W        8   width of session byte count
//  TIMEOUT_CYC  16  max cycles spent in WAIT before abort (only with SAE_TIMEOUT_EN)
// PORTS
//  clk           in   1      clock
//  rst           in   1      asynchronous, active-high reset
//  cmd_start     in   1      1-cycle pulse; latches cmd_mode/cmd_key/cmd_len when idle
//  cmd_mode      in   2      01 keygen, 10 encrypt, 11 decrypt (00 = no-op)
//  cmd_key       in   8      private key (keygen/decrypt) or peer public key (encrypt)
//  cmd_len       in   LEN_W  bytes in session (ignored for keygen, forced to 1)
//  busy          out  1      session active
//  done          out  1      1-cycle pulse at session end
//  s_valid       in   1      input byte valid
//  s_data        in   8      input byte (ptxt or ctxt char)
//  s_ready       out  1      input byte accepted when s_valid&s_ready
//  m_valid       out  1      result valid
//  m_data        out  8      result byte (pubkey/ctxt/ptxt)
//  m_err         out  4      {timeout, inv_ctxt, inv_seckey, inv_ptxt}
//  m_ready       in   1      result consumed when m_valid&m_ready
//  err_cnt       out  8      saturating count of results with m_err!=0 this session
//  sae_mode      out  2      to sae.mode
//  sae_data      out  8      to sae.data_input
//  sae_key       out  8      to sae.key_input
//  sae_valid     out  1      to sae.inputs_valid
//  sae_dout      in   8      from sae.data_output
//  sae_ordy      in   1      from sae.output_ready
//  sae_err       in   3      {err_invalid_ctxt_char, err_invalid_seckey, err_invalid_ptxt_char}
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Applies immediately (async), including mid-session; no partial result emitted.
//  FSM: IDLE -> FETCH -> ISSUE -> WAIT -> EMIT -> (FETCH | DONE) -> IDLE.
//  IDLE:  sae_mode=00.
//         cmd_start && cmd_mode!=00: latch mode/key; rem=(keygen?1:cmd_len); err_cnt=0; busy=1.
//         Then keygen -> ISSUE with byte 8'h00; rem==0 -> DONE; else -> FETCH.
//         cmd_start while busy, or with mode 00, is ignored.
//  FETCH: s_ready=1. On s_valid, latch s_data -> ISSUE.
//  ISSUE: sae_valid=1 for exactly one cycle -> WAIT.
//         sae_mode/sae_key are held stable for the whole session; sae_data is held from ISSUE through WAIT.
//  WAIT:  sampled starting the cycle after ISSUE.
//         sae_ordy || |sae_err -> capture m_data=sae_dout, m_err[2:0]=sae_err -> EMIT.
//         sae_err has priority: m_err is set even if sae_ordy is also 1.
//  EMIT:  m_valid=1; m_data/m_err held until m_ready.
//         On handshake: rem-=1; err_cnt+=(m_err!=0), saturating at 255; rem==0 -> DONE, else FETCH.
//         An error byte does not abort the session.
//  DONE:  done=1 for one cycle, busy=0, sae_mode=00 -> IDLE.
//  Max one outstanding sae request. Throughput: 1 byte per 4 cycles with no stalls.
//  s_ready and m_valid are never high in the same cycle.
// CONFIGURATION
//  SAE_TIMEOUT_EN defined:
//   - WAIT cycle counter; at TIMEOUT_CYC cycles without sae_ordy/sae_err -> EMIT with m_data=0, m_err=4'b1000.
//   - A late sae_ordy arriving after the timeout is ignored.
//  SAE_TIMEOUT_EN undefined: m_err[3] tied 0; WAIT holds indefinitely; no counter logic.
// STRUCTURE
//  sae_pkg: sae_mode_t enum (IDLE=2'b00, KEYGEN=2'b01, ENC=2'b10, DEC=2'b11),
//   seq_state_t enum, ERR_PTXT/ERR_SECKEY/ERR_CTXT/ERR_TIMEOUT bit indices.
//  Sub-module sae_wait_timer: load/count/expire watchdog, instantiated only under SAE_TIMEOUT_EN.
// TESTING
//  1. Keygen: cmd_key=8'h5A, sae stub returns 8'hC3 1 cycle after sae_valid
//     -> one sae_valid with sae_data=00; m_data=C3, m_err=0; done pulses once.
//  2. Encrypt, len=3, bytes 61,62,63; stub returns x+1
//     -> three sae_valid pulses with sae_mode=10 held; m_data=62,63,64 in order; err_cnt=0.
//  3. Backpressure: m_ready low 5 cycles during EMIT
//     -> m_valid/m_data stable, s_ready=0, no new sae_valid.
//  4. Decrypt byte 7E with stub err_invalid_ctxt_char
//     -> m_err=4'b0100, err_cnt=1; next byte still processed.
//  5. SAE_TIMEOUT_EN, TIMEOUT_CYC=16, stub never ready
//     -> m_valid with m_err=4'b1000 after 16 WAIT cycles.
//     Without the macro -> busy stays 1.
//  6. Reset asserted in WAIT -> sae_valid, busy, m_valid=0 immediately.
//     Then encrypt with len=0 -> done within 2 cycles, no sae_valid.

Source files
------------

// File: rtl/sae_pkg.sv
// ---------------------------------------------------------------------------
// sae_pkg
// Shared types and constants for the sae host-side sequencer.
//   sae_mode_t  : operation code driven onto the sae core mode input
//   seq_state_t : sequencer FSM states
//   ERR_*       : bit positions inside the 4-bit result error tag
//   err_flags() : packs a core error vector plus the timeout flag into a tag
// ---------------------------------------------------------------------------
package sae_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        KEYGEN = 2'b01,
        ENC    = 2'b10,
        DEC    = 2'b11
    } sae_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } seq_state_t;

    localparam int ERR_PTXT    = 0;
    localparam int ERR_SECKEY  = 1;
    localparam int ERR_CTXT    = 2;
    localparam int ERR_TIMEOUT = 3;

    // core_err arrives as {inv_ctxt, inv_seckey, inv_ptxt}
    function automatic logic [3:0] err_flags(input logic timeout, input logic [2:0] core_err);
        logic [3:0] f;
        f              = '0;
        f[ERR_TIMEOUT] = timeout;
        f[ERR_CTXT]    = core_err[2];
        f[ERR_SECKEY]  = core_err[1];
        f[ERR_PTXT]    = core_err[0];
        return f;
    endfunction

endpackage

// File: rtl/sae_wait_timer.sv
// ---------------------------------------------------------------------------
// sae_wait_timer
// Watchdog for the sequencer WAIT state. Only exists when SAE_TIMEOUT_EN is
// defined; the default build has no timer logic at all.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_load      : restart the count (asserted the cycle before WAIT begins)
//   i_count     : advance one step per WAIT cycle
//   o_expired   : high in the TIMEOUT_CYC-th consecutive WAIT cycle
// ---------------------------------------------------------------------------
`ifdef SAE_TIMEOUT_EN
module sae_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;

    // r_cnt holds the number of WAIT cycles already elapsed, so the
    // TIMEOUT_CYC-th cycle sees TIMEOUT_CYC-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = i_count && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/sae_host_seq.sv
// ---------------------------------------------------------------------------
// sae_host_seq
// Host-side initiator for the sae crypto core. A session command (keygen,
// encrypt, decrypt) plus an input byte stream is turned into one sae request
// per byte; each core result is returned on an output stream tagged with
// error flags. At most one request is outstanding at any time.
//
// Optional feature: define SAE_TIMEOUT_EN to add a WAIT watchdog
// (parameter TIMEOUT_CYC, sub-module sae_wait_timer). Without it, WAIT holds
// until the core answers and m_err[3] is always 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_start/mode/key/len    session command, sampled when idle
//   busy, done                session active / end-of-session pulse
//   s_valid/s_data/s_ready    input byte stream
//   m_valid/m_data/m_err/m_ready  result stream, m_err={timeout,ctxt,seckey,ptxt}
//   err_cnt                   saturating count of errored results this session
//   sae_mode/data/key/valid   request side of the sae core
//   sae_dout/ordy/err         response side of the sae core
// ---------------------------------------------------------------------------
module sae_host_seq
    import sae_pkg::*;
#(
    parameter int LEN_W = 8
`ifdef SAE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic [1:0]       cmd_mode,
    input  logic [7:0]       cmd_key,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic [3:0]       m_err,
    input  logic             m_ready,
    output logic [7:0]       err_cnt,
    output logic [1:0]       sae_mode,
    output logic [7:0]       sae_data,
    output logic [7:0]       sae_key,
    output logic             sae_valid,
    input  logic [7:0]       sae_dout,
    input  logic             sae_ordy,
    input  logic [2:0]       sae_err
);

    seq_state_t       r_state;
    sae_mode_t        r_sae_mode;
    logic [LEN_W-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic             r_s_ready;
    logic             r_m_valid;
    logic [7:0]       r_m_data;
    logic [3:0]       r_m_err;
    logic [7:0]       r_err_cnt;
    logic [7:0]       r_sae_data;
    logic [7:0]       r_sae_key;
    logic             r_sae_valid;

    logic             w_resp;
    logic             w_last;
    logic             w_expired;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF)) begin
            return v + 8'd1;
        end
        return v;
    endfunction

    // An error flag alone is a complete response from the core.
    assign w_resp = sae_ordy | (|sae_err);
    assign w_last = (r_rem == LEN_W'(1));

`ifdef SAE_TIMEOUT_EN
    logic w_tmr_load;
    logic w_tmr_count;

    assign w_tmr_load  = (r_state == ST_ISSUE);
    assign w_tmr_count = (r_state == ST_WAIT);

    sae_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_tmr_load),
        .i_count   (w_tmr_count),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sae_mode  <= IDLE;
            r_rem       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_err     <= '0;
            r_err_cnt   <= '0;
            r_sae_data  <= '0;
            r_sae_key   <= '0;
            r_sae_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start && (cmd_mode != 2'b00)) begin
                        r_sae_mode <= sae_mode_t'(cmd_mode);
                        r_sae_key  <= cmd_key;
                        r_err_cnt  <= '0;
                        if (sae_mode_t'(cmd_mode) == KEYGEN) begin
                            // Keygen is a single request with a zero data byte.
                            r_rem       <= LEN_W'(1);
                            r_busy      <= 1'b1;
                            r_sae_data  <= 8'h00;
                            r_sae_valid <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end else if (cmd_len == '0) begin
                            // Empty session: straight to the end pulse.
                            r_rem      <= '0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_sae_mode <= IDLE;
                            r_state    <= ST_DONE;
                        end else begin
                            r_rem     <= cmd_len;
                            r_busy    <= 1'b1;
                            r_s_ready <= 1'b1;
                            r_state   <= ST_FETCH;
                        end
                    end
                end

                ST_FETCH: begin
                    if (s_valid) begin
                        r_s_ready   <= 1'b0;
                        r_sae_data  <= s_data;
                        r_sae_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_sae_valid <= 1'b0;
                    r_state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A core response in the final watchdog cycle still wins.
                    if (w_resp) begin
                        r_m_data  <= sae_dout;
                        r_m_err   <= err_flags(1'b0, sae_err);
                        r_m_valid <= 1'b1;
                        r_state   <= ST_EMIT;
                    end else if (w_expired) begin
                        r_m_data  <= 8'h00;
                        r_m_err   <= err_flags(1'b1, 3'b000);
                        r_m_valid <= 1'b1;
                        r_state   <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_rem     <= r_rem - LEN_W'(1);
                        r_err_cnt <= sat_inc(r_err_cnt, |r_m_err);
                        if (w_last) begin
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_sae_mode <= IDLE;
                            r_state    <= ST_DONE;
                        end else begin
                            r_s_ready <= 1'b1;
                            r_state   <= ST_FETCH;
                        end
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_err     = r_m_err;
    assign err_cnt   = r_err_cnt;
    assign sae_mode  = r_sae_mode;
    assign sae_data  = r_sae_data;
    assign sae_key   = r_sae_key;
    assign sae_valid = r_sae_valid;

endmodule

// File: tb/tb_sae_host_seq.sv
// ---------------------------------------------------------------------------
// tb_sae_host_seq
// Directed sessions against sae_host_seq with a behavioural sae core stub.
// Expected sae requests and expected results are queued when stimulus is
// issued; a negedge monitor pops and compares them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_sae_host_seq;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] key;
    } req_t;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_start = 1'b0;
    logic [1:0] cmd_mode  = 2'b00;
    logic [7:0] cmd_key   = 8'h00;
    logic [7:0] cmd_len   = 8'h00;
    logic       busy;
    logic       done;
    logic       s_valid   = 1'b0;
    logic [7:0] s_data    = 8'h00;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic [3:0] m_err;
    logic       m_ready   = 1'b1;
    logic [7:0] err_cnt;
    logic [1:0] sae_mode;
    logic [7:0] sae_data;
    logic [7:0] sae_key;
    logic       sae_valid;
    logic [7:0] sae_dout  = 8'h00;
    logic       sae_ordy  = 1'b0;
    logic [2:0] sae_err   = 3'b000;

    int vectors     = 0;
    int miscompares = 0;
    int req_seen    = 0;
    int done_cnt    = 0;
    int stub_mode   = 0;

    req_t        exp_req[$];
    logic [11:0] exp_res[$];

    sae_host_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_start (cmd_start),
        .cmd_mode  (cmd_mode),
        .cmd_key   (cmd_key),
        .cmd_len   (cmd_len),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_err     (m_err),
        .m_ready   (m_ready),
        .err_cnt   (err_cnt),
        .sae_mode  (sae_mode),
        .sae_data  (sae_data),
        .sae_key   (sae_key),
        .sae_valid (sae_valid),
        .sae_dout  (sae_dout),
        .sae_ordy  (sae_ordy),
        .sae_err   (sae_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // sae core stub: answers one cycle after the request pulse.
    // 0: constant C3, 1: x+1, 2: x+1 but byte 7E flags inv_ctxt only, 3: silent
    always @(posedge clk) begin
        sae_ordy <= 1'b0;
        sae_err  <= 3'b000;
        if (sae_valid) begin
            case (stub_mode)
                0: begin
                    sae_ordy <= 1'b1;
                    sae_dout <= 8'hC3;
                end
                1: begin
                    sae_ordy <= 1'b1;
                    sae_dout <= sae_data + 8'd1;
                end
                2: begin
                    sae_dout <= sae_data + 8'd1;
                    if (sae_data == 8'h7E) sae_err  <= 3'b100;
                    else                   sae_ordy <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        req_t        r;
        logic [11:0] e;
        if (done) done_cnt++;
        if (sae_valid) begin
            req_seen++;
            if (exp_req.size() == 0) begin
                miscompares++;
                $display("FAIL sae_req: unexpected request data=%0h", sae_data);
            end else begin
                r = exp_req.pop_front();
                check("sae_mode", sae_mode, r.mode);
                check("sae_data", sae_data, r.data);
                check("sae_key",  sae_key,  r.key);
            end
        end
        if (m_valid && m_ready) begin
            if (exp_res.size() == 0) begin
                miscompares++;
                $display("FAIL m_result: unexpected result data=%0h err=%0h", m_data, m_err);
            end else begin
                e = exp_res.pop_front();
                check("m_data", m_data, e[11:4]);
                check("m_err",  m_err,  e[3:0]);
            end
        end
        if (m_valid && s_ready) begin
            miscompares++;
            $display("FAIL s_ready_m_valid_overlap: got both 1, expected exclusive");
        end
    end

    task automatic start_cmd(input logic [1:0] mode, input logic [7:0] key, input logic [7:0] len);
        @(posedge clk);
        #1;
        cmd_start = 1'b1;
        cmd_mode  = mode;
        cmd_key   = key;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        cmd_mode  = 2'b00;
    endtask

    task automatic feed(input logic [7:0] b);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("feed_accept", ok, 1);
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, done, s_ready, m_valid, sae_valid, sae_mode, m_err}, 0);
        check("rst_data", {m_data, err_cnt, sae_data, sae_key}, 0);
        rst = 1'b0;

        // 1: keygen, stub returns C3
        stub_mode = 0;
        exp_req.push_back({2'b01, 8'h00, 8'h5A});
        exp_res.push_back({8'hC3, 4'h0});
        start_cmd(2'b01, 8'h5A, 8'd9);
        check("t1_busy", busy, 1);
        wait_done(20, "t1_done");
        check("t1_reqs", req_seen, 1);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_busy_end", busy, 0);

        // 2: encrypt three bytes, stub returns x+1
        stub_mode = 1;
        exp_req.push_back({2'b10, 8'h61, 8'h11});
        exp_req.push_back({2'b10, 8'h62, 8'h11});
        exp_req.push_back({2'b10, 8'h63, 8'h11});
        exp_res.push_back({8'h62, 4'h0});
        exp_res.push_back({8'h63, 4'h0});
        exp_res.push_back({8'h64, 4'h0});
        start_cmd(2'b10, 8'h11, 8'd3);
        feed(8'h61);
        feed(8'h62);
        feed(8'h63);
        wait_done(30, "t2_done");
        check("t2_reqs", req_seen, 4);
        check("t2_err_cnt", err_cnt, 0);
        check("t2_done_cnt", done_cnt, 2);
        check("t2_res_left", exp_res.size(), 0);

        // 3: result backpressure
        m_ready = 1'b0;
        exp_req.push_back({2'b10, 8'h10, 8'h22});
        exp_req.push_back({2'b10, 8'h20, 8'h22});
        exp_res.push_back({8'h11, 4'h0});
        exp_res.push_back({8'h21, 4'h0});
        start_cmd(2'b10, 8'h22, 8'd2);
        feed(8'h10);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (m_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t3_m_valid_seen", seen, 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", m_valid, 1);
            check("t3_hold_data", m_data, 8'h11);
            check("t3_s_ready", s_ready, 0);
            check("t3_no_new_req", req_seen, 5);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        feed(8'h20);
        wait_done(30, "t3_done");
        check("t3_reqs", req_seen, 6);
        check("t3_done_cnt", done_cnt, 3);

        // 4: decrypt with an invalid ciphertext byte, session continues
        stub_mode = 2;
        exp_req.push_back({2'b11, 8'h7E, 8'h33});
        exp_req.push_back({2'b11, 8'h41, 8'h33});
        exp_res.push_back({8'h7F, 4'b0100});
        exp_res.push_back({8'h42, 4'b0000});
        start_cmd(2'b11, 8'h33, 8'd2);
        feed(8'h7E);
        feed(8'h41);
        wait_done(30, "t4_done");
        check("t4_err_cnt", err_cnt, 1);
        check("t4_reqs", req_seen, 8);
        check("t4_done_cnt", done_cnt, 4);

        // 5: core never answers
        stub_mode = 3;
        exp_req.push_back({2'b10, 8'h55, 8'h44});
        start_cmd(2'b10, 8'h44, 8'd1);
`ifdef SAE_TIMEOUT_EN
        exp_res.push_back({8'h00, 4'b1000});
        feed(8'h55);
        begin
            int n;
            bit seen;
            n    = 0;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                n++;
                if (m_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t5_timeout_seen", seen, 1);
            // 1 ISSUE cycle + 16 WAIT cycles, result visible on the next
            check("t5_timeout_latency", n, 18);
        end
        wait_done(10, "t5_done");
        check("t5_err_cnt", err_cnt, 1);
        check("t5_done_cnt", done_cnt, 5);
        // second silent session, left hanging in WAIT for the reset test
        exp_req.push_back({2'b10, 8'h56, 8'h45});
        start_cmd(2'b10, 8'h45, 8'd1);
        feed(8'h56);
        repeat (3) @(negedge clk);
        check("t5_reqs", req_seen, 10);
`else
        feed(8'h55);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (m_valid) seen = 1'b1;
            end
            check("t5_no_result", seen, 0);
            check("t5_busy_held", busy, 1);
            check("t5_reqs", req_seen, 9);
        end
`endif

        // 6: asynchronous reset while in WAIT
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl", {sae_valid, busy, m_valid, s_ready, done}, 0);
        check("t6_rst_data", {m_data, err_cnt, sae_mode}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        stub_mode = 1;
        start_cmd(2'b10, 8'h66, 8'd0);
        wait_done(2, "t6_len0_done");
        repeat (3) @(negedge clk);
`ifdef SAE_TIMEOUT_EN
        check("t6_no_req", req_seen, 10);
        check("t6_done_cnt", done_cnt, 6);
`else
        check("t6_no_req", req_seen, 9);
        check("t6_done_cnt", done_cnt, 5);
`endif
        check("t6_busy_idle", busy, 0);
        check("end_req_queue", exp_req.size(), 0);
        check("end_res_queue", exp_res.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
